// File: rtl/audio_tone_pkg.sv
// Shared constants and types for the tone step generator: base-octave period table and decode FSM states.
`default_nettype none

package audio_tone_pkg;

  localparam int SEMITONES = 12;
  localparam int TONE_REST = 0;

  // 100 MHz cycles per waveform step for C3..B3 (32 steps per waveform).
  localparam logic [15:0] BASE_PERIOD [0:11] = '{
    16'd23890, 16'd22549, 16'd21283, 16'd20089, 16'd18961, 16'd17897,
    16'd16892, 16'd15944, 16'd15050, 16'd14205, 16'd13408, 16'd12655
  };

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_DIVIDE = 1'b1
  } calc_state_t;

  function automatic logic [15:0] base_period(input logic [3:0] idx);
    logic [15:0] r;
    r = 16'd0;
    for (int i = 0; i < SEMITONES; i++) begin
      if (idx == 4'(i)) r = BASE_PERIOD[i];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tone_step_gen_if.sv
// Control/status bundle between the AudioController and the tone step generator.
`default_nettype none

interface tone_step_gen_if #(
  parameter int TONE_W    = 6,
  parameter int STEP_BITS = 5,
  parameter int PERIOD_W  = 16
);
  logic                 enable;
  logic [TONE_W-1:0]    tone_in;
  logic                 tone_load;
  logic                 busy;
  logic [PERIOD_W-1:0]  period_out;
  logic [STEP_BITS-1:0] step_idx;
  logic                 step_tick;
  logic                 wave_start;

  modport master (
    output enable, tone_in, tone_load,
    input  busy, period_out, step_idx, step_tick, wave_start
  );

  modport slave (
    input  enable, tone_in, tone_load,
    output busy, period_out, step_idx, step_tick, wave_start
  );
endinterface

`default_nettype wire

// File: rtl/tone_step_gen_period_calc.sv
// tone_period_calc: tone number -> step period by repeated subtract-12 and an octave right shift.
`default_nettype none

module tone_period_calc
  import audio_tone_pkg::*;
#(
  parameter int NUM_OCTAVES = 4,
  parameter int TONE_W      = 6,
  parameter int PERIOD_W    = 16
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic                i_load,
  input  wire logic [TONE_W-1:0]   i_tone,
  output logic      [PERIOD_W-1:0] o_target,
  output logic                     o_target_valid,
  output logic                     o_busy
);

  localparam int OCT_W    = (NUM_OCTAVES < 1) ? 1 : $clog2(NUM_OCTAVES + 1);
  localparam int MAX_TONE = SEMITONES * NUM_OCTAVES;

  calc_state_t         r_state;
  calc_state_t         w_state_nxt;
  logic [TONE_W-1:0]   r_rem;
  logic [OCT_W-1:0]    r_oct;
  logic [PERIOD_W-1:0] r_target;
  logic                r_target_valid;
  logic                w_tone_ok;
  logic                w_rem_ge;
  logic [15:0]         w_shifted;

  assign w_tone_ok = (i_tone != TONE_W'(TONE_REST)) && (int'(i_tone) <= MAX_TONE);
  assign w_rem_ge  = (r_rem >= TONE_W'(SEMITONES));
  assign w_shifted = base_period(r_rem[3:0]) >> r_oct;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_load && w_tone_ok) w_state_nxt = ST_DIVIDE;
      ST_DIVIDE: if (!w_rem_ge)           w_state_nxt = ST_IDLE;
      default:                            w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy         = (r_state == ST_DIVIDE);
    o_target       = r_target;
    o_target_valid = r_target_valid;
  end

  // Invalid tones and rests resolve to a silent target without entering DIVIDE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem          <= '0;
      r_oct          <= '0;
      r_target       <= '0;
      r_target_valid <= 1'b0;
    end else begin
      r_target_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_load) begin
            if (w_tone_ok) begin
              r_rem <= i_tone - 1'b1;
              r_oct <= '0;
            end else begin
              r_target       <= '0;
              r_target_valid <= 1'b1;
            end
          end
        end
        ST_DIVIDE: begin
          if (w_rem_ge) begin
            r_rem <= r_rem - TONE_W'(SEMITONES);
            r_oct <= r_oct + 1'b1;
          end else begin
            r_target       <= PERIOD_W'(w_shifted);
            r_target_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/tone_step_gen.sv
// tone_step_gen: tone decode, boundary-synchronous period apply and waveform step counter.
// Optional macro TONE_GLIDE_EN: glide the period toward a new target one fraction per waveform.
`default_nettype none

module tone_step_gen
  import audio_tone_pkg::*;
#(
  parameter int STEP_BITS   = 5,
  parameter int NUM_OCTAVES = 4,
  parameter int TONE_W      = 6,
  parameter int PERIOD_W    = 16,
  parameter int GLIDE_SHIFT = 3
) (
  input wire logic     clk,
  input wire logic     rst_n,
  tone_step_gen_if.slave bus
);

  logic [PERIOD_W-1:0]  w_target;
  logic                 w_target_valid;
  logic                 w_busy;
  logic [PERIOD_W-1:0]  r_period;
  logic [PERIOD_W-1:0]  r_cnt;
  logic [STEP_BITS-1:0] r_idx;
  logic                 r_tick;
  logic                 r_wave;
  logic                 w_run;
  logic                 w_step_end;
  logic                 w_wrap;
  logic [PERIOD_W-1:0]  w_next_period;
  logic                 w_unused;

  tone_period_calc #(
    .NUM_OCTAVES (NUM_OCTAVES),
    .TONE_W      (TONE_W),
    .PERIOD_W    (PERIOD_W)
  ) u_calc (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_load         (bus.tone_load),
    .i_tone         (bus.tone_in),
    .o_target       (w_target),
    .o_target_valid (w_target_valid),
    .o_busy         (w_busy)
  );

  assign w_unused   = ^{w_target_valid, 1'(GLIDE_SHIFT)};
  assign w_run      = bus.enable && (r_period != '0);
  assign w_step_end = w_run && (r_cnt == r_period - 1'b1);
  assign w_wrap     = w_step_end && (r_idx == '1);

`ifdef TONE_GLIDE_EN
  logic signed [PERIOD_W:0] w_diff;
  logic signed [PERIOD_W:0] w_abs;
  logic signed [PERIOD_W:0] w_glide_step;

  always_comb begin
    w_diff        = $signed({1'b0, w_target}) - $signed({1'b0, r_period});
    w_abs         = w_diff[PERIOD_W] ? -w_diff : w_diff;
    w_glide_step  = w_diff >>> GLIDE_SHIFT;
    w_next_period = w_target;
    if ((w_target != '0) && (r_period != '0) && ((w_abs >>> GLIDE_SHIFT) != '0))
      w_next_period = r_period + w_glide_step[PERIOD_W-1:0];
  end
`else
  always_comb begin
    w_next_period = w_target;
  end
`endif

  // Outside a running wave the target is taken as-is; a running wave only changes period at its wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= '0;
    end else if (w_wrap) begin
      r_period <= w_next_period;
    end else if ((r_period == '0) || !bus.enable) begin
      r_period <= w_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_tick <= 1'b0;
      r_wave <= 1'b0;
    end else if (!w_run) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_tick <= 1'b0;
      r_wave <= 1'b0;
    end else begin
      r_tick <= w_step_end;
      r_wave <= w_wrap;
      if (w_step_end) begin
        r_cnt <= '0;
        r_idx <= r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.busy       = w_busy;
  assign bus.period_out = r_period;
  assign bus.step_idx   = r_idx;
  assign bus.step_tick  = r_tick;
  assign bus.wave_start = r_wave;

endmodule

`default_nettype wire
